// File: rtl/mips_muldiv.sv
// mips_muldiv -- iterative multiply/divide unit with HI/LO result registers.
//
// Works alongside the single-cycle ALU. It computes one radix-2 step per clock:
// shift-add for MULT/MULTU and restoring shift-subtract for DIV/DIVU. The core
// always works on unsigned magnitudes. Signs are applied once, on the last step.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     launch op with a/b (only honoured in IDLE)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      rs / rt operands
//   wr_hi     MTHI: hi <= wd (IDLE only)
//   wr_lo     MTLO: lo <= wd (IDLE only)
//   wd        MTHI/MTLO write data
//   busy      unit is not idle (controller stalls the PC)
//   done      one-cycle pulse, hi/lo hold the new result
//   div_zero  the last DIV/DIVU had b == 0
//   hi, lo    HI/LO architectural registers
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;          // product / quotient sign
    logic               rem_neg_q, rem_neg_d;  // remainder follows the dividend
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   opb_q, opb_d;          // |b|: multiplicand addend or divisor
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;    // partial product high / partial remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;    // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes. The unsigned ops bypass the negation.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (-a) : a;
    assign b_mag = b_neg ? (-b) : b;

    // Multiply step. The running sum and the multiplier shift right together as one 2W+1 register.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo;

    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Restoring divide step. A borrow out of the W+1-bit subtract means the trial failed.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi, div_lo;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo    = {acc_lo_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    assign prod = {mul_hi, mul_lo};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wd;
                if (wr_lo) lo_d = wd;
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = CNT_W'(WIDTH);
                    is_div_d  = op[1];
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = op[1] & (b == '0);
                    opb_d     = b_mag;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                end
            end
            S_RUN: begin
                cnt_d    = cnt_q - CNT_W'(1);
                acc_hi_d = is_div_q ? div_hi : mul_hi;
                acc_lo_d = is_div_q ? div_lo : mul_lo;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        // With a zero divisor the quotient is all ones. The remainder is
                        // |a|, and the remainder sign fix-up restores it to a.
                        lo_d = dz_q ? '1 : (neg_q ? (-div_lo) : div_lo);
                        hi_d = rem_neg_q ? (-div_hi) : div_hi;
                    end else begin
                        {hi_d, lo_d} = neg_q ? (-prod) : prod;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] wd = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with plain 64-bit / int arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        logic [63:0] p;
        int sx, sy;
        ez = o[1] && (y == 32'd0);
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {eh, el} = p;
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                {eh, el} = p;
            end
            2'b10: begin
                if (y == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'd0;
                end else begin
                    sx = x; sy = y;
                    el = sx / sy;
                    eh = sx % sy;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // One full operation. inj_cyc: cycle in which start+wr_hi are pulsed mid-run.
    // inj_done: pulse start during the DONE cycle. wr_at_start: MTLO on the launch edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inj_cyc, input bit inj_done, input bit wr_at_start,
                         input logic [31:0] wdat);
        logic [31:0] eh, el;
        logic ez;
        int dcyc;
        bit bok;
        model(o, x, y, eh, el, ez);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (wr_at_start) begin wr_lo = 1'b1; wd = wdat; end
        @(posedge clk);
        #1;
        start = 1'b0; wr_lo = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        dcyc = 0;
        bok = 1'b1;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            @(negedge clk);
            if (c == 1 && wr_at_start) chk("wr_lo_with_start", lo, wdat);
            if (c == inj_cyc) begin
                start = 1'b1; wr_hi = 1'b1; wd = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; wr_hi = 1'b0;
            end
            if (done) dcyc = c;
            else if (!busy) bok = 1'b0;
        end
        start = 1'b0; wr_hi = 1'b0;
        chk("done_cycle", dcyc, 33);
        chk("busy_while_running", 32'(bok), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("div_zero", 32'(div_zero), 32'(ez));
        if (inj_done) begin
            start = 1'b1; op = o; a = x; b = y;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_pulse", 32'(done), 32'd0);
        chk("hi_stable", hi, eh);
        chk("lo_stable", lo, el);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h div_zero=%0d done_cycle=%0d",
                 o, x, y, hi, lo, div_zero, dcyc);
    endtask

    initial begin : main
        int seen;
        logic [1:0] ro;
        logic [31:0] rx, ry;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MTLO alone, then MTHI+MTLO together
        @(negedge clk);
        wr_lo = 1'b1; wd = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi_untouched", hi, 32'd0);
        $display("mtlo wd=00001234 -> hi=%h lo=%h", hi, lo);
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hA5A5_0F0F;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mthi_mtlo_hi", hi, 32'hA5A5_0F0F);
        chk("mthi_mtlo_lo", lo, 32'hA5A5_0F0F);
        $display("mthi+mtlo wd=a5a50f0f -> hi=%h lo=%h", hi, lo);

        // Directed operations
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0, '0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0);
        do_op(2'b11, 32'd100, 32'd7, 0, 1'b0, 1'b0, '0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, '0);
        do_op(2'b10, 32'd5, 32'd0, 0, 1'b0, 1'b0, '0);
        do_op(2'b11, 32'd8, 32'd2, 0, 1'b0, 1'b0, '0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0);
        do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0, 1'b0, 1'b0, '0);
        // start + MTHI mid-run ignored; start in DONE ignored; MTLO on the launch edge lands
        do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, 1'b0, '0);
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, 1'b0, 1'b1, 32'h0BAD_F00D);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = pick();
            ry = pick();
            do_op(ro, rx, ry, 0, 1'b0, 1'b0, '0);
        end

        // Reset in cycle 10 of a DIV (b==0 so div_zero would otherwise be set)
        @(negedge clk);
        op = 2'b10; a = 32'd100; b = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrst_no_activity", 32'(seen), 32'd0);
        chk("midrst_hi_after", hi, 32'd0);
        chk("midrst_lo_after", lo, 32'd0);
        $display("reset in cycle 10 of DIV -> busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
